mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's data bus, downstream of the datapath's bus outputs and parallel to the data memory interface.
- Decodes bus_address/bus_write_enable/bus_read_enable against its own window and buffers written bytes in a FIFO.
- Serialises bytes onto an 8N1 TX line at a programmable divisor.
- Read data is combinational from registered state so the single-cycle core sees it in the same cycle.

---
 rtl/mmio_uart_tx_pkg.sv | 30 +++
 rtl/mmio_uart_tx_sync_fifo.sv | 57 +++++
 rtl/mmio_uart_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: register map, STATUS layout and FSM encoding
// shared by the UART transmitter and its FIFO.
package mmio_uart_tx_pkg;

    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_DIVISOR = 2'd2;
    localparam logic [1:0] UART_RSVD    = 2'd3;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_EMPTY  = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_CNT_LO = 4;
    localparam int STAT_CNT_HI = 7;
    localparam int STAT_PARITY = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic [3:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// mmio_uart_tx_sync_fifo: single-clock FIFO, power-of-two depth,
// pointers wrap by masking; read data is the head entry.
module mmio_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr + AW'(1)) & MASK;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr + AW'(1)) & MASK;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries behind count are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 UART transmitter with TX FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit per frame.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'hFF00_0000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [2:0]  data_format,
    input  logic        read_enable,
    input  logic        write_enable,
    output logic [31:0] data_fetched,
    output logic        selected,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    offset;
    logic          is_txdata;
    logic          is_status;
    logic          is_divisor;
    logic          is_rsvd;
    logic          wr_txdata;
    logic          wr_divisor;
    logic          rd_status;

    logic [15:0]   divisor;
    logic [15:0]   div_eff;
    logic          overflow;

    uart_state_e   state;
    uart_state_e   next_state;
    logic [15:0]   baud_cnt;
    logic [15:0]   d_lat;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          baud_tick;
    logic          busy;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count;

    logic [31:0]   status_word;
    logic          par_flag;
    logic          unused_bits;

    assign unused_bits = ^{data_format, address[1:0], write_data[31:16]};

    assign selected   = address[31:4] == BASE_ADDR[31:4];
    assign offset     = address[3:2];
    assign is_txdata  = offset == UART_TXDATA;
    assign is_status  = offset == UART_STATUS;
    assign is_divisor = offset == UART_DIVISOR;
    assign is_rsvd    = offset == UART_RSVD;

    assign wr_txdata  = selected && write_enable && is_txdata;
    assign wr_divisor = selected && write_enable && is_divisor;
    assign rd_status  = selected && read_enable && is_status;

    // A full FIFO still accepts a byte when the FSM drains one this cycle.
    assign fifo_push  = wr_txdata && (!fifo_full || fifo_pop);

    assign div_eff    = (divisor == 16'd0) ? 16'd1 : divisor;
    assign baud_tick  = baud_cnt == 16'd0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            divisor  <= DEFAULT_DIVISOR;
            overflow <= 1'b0;
        end else begin
            if (wr_divisor) begin
                divisor <= write_data[15:0];
            end
            if (wr_txdata && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end else if (rd_status) begin
                overflow <= 1'b0;
            end
        end
    end

    mmio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (write_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    next_state = ST_PARITY;
`else
                    next_state = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    next_state = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    next_state = fifo_empty ? ST_IDLE : ST_START;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        tx       = 1'b1;
        fifo_pop = 1'b0;
        unique case (state)
            ST_IDLE:   fifo_pop = !fifo_empty;
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = par_flag;
`endif
            ST_STOP:   fifo_pop = baud_tick && !fifo_empty;
            default:   tx = 1'b1;
        endcase
    end

    assign busy = state != ST_IDLE;
    assign irq  = fifo_empty && !busy;

    // The divisor is captured per frame so mid-frame writes wait a frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            baud_cnt <= '0;
            d_lat    <= 16'd1;
            bit_cnt  <= '0;
            shift    <= '0;
        end else if (fifo_pop) begin
            baud_cnt <= div_eff - 16'd1;
            d_lat    <= div_eff;
            bit_cnt  <= '0;
            shift    <= fifo_data;
        end else if (busy) begin
            if (baud_tick) begin
                baud_cnt <= d_lat - 16'd1;
                if (state == ST_DATA) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt - 16'd1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            par_flag <= 1'b0;
        end else if (fifo_pop) begin
            par_flag <= ^fifo_data;
        end
    end
`else
    assign par_flag = 1'b0;
`endif

    always_comb begin
        status_word = '0;
        status_word[STAT_BUSY]  = busy;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_OVF]   = overflow;
        status_word[STAT_CNT_HI:STAT_CNT_LO] =
            sat_count(32'(fifo_count));
`ifdef UART_TX_PARITY_EN
        status_word[STAT_PARITY] = 1'b1;
`else
        status_word[STAT_PARITY] = par_flag;
`endif
    end

    always_comb begin
        data_fetched = '0;
        if (selected) begin
            unique case (1'b1)
                is_status:  data_fetched = status_word;
                is_divisor: data_fetched = {16'd0, divisor};
                is_txdata:  data_fetched = '0;
                is_rsvd:    data_fetched = '0;
                default:    data_fetched = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and random bus traffic against a
// frame-level reference model of the UART transmitter.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'hFF00_0000;
    localparam int          DEPTH = 8;
    localparam logic [15:0] DEFD  = 16'd434;
`ifdef UART_TX_PARITY_EN
    localparam logic [31:0] PAR   = 32'h100;
    localparam int          NBITS = 11;
`else
    localparam logic [31:0] PAR   = 32'h0;
    localparam int          NBITS = 10;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [2:0]  data_format;
    logic        read_enable;
    logic        write_enable;
    logic [31:0] data_fetched;
    logic        selected;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    logic [7:0]  mq[$];
    bit          m_active;
    int          m_pos;
    int          m_d;
    logic [7:0]  m_byte;
    logic [15:0] m_div;
    bit          m_ovf;

    mmio_uart_tx dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .write_data   (write_data),
        .data_format  (data_format),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .data_fetched (data_fetched),
        .selected     (selected),
        .tx           (tx),
        .irq          (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int flen();
        return NBITS * m_d;
    endfunction

    function automatic logic exp_tx();
        int k;
        if (!m_active) return 1'b1;
        k = m_pos / m_d;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        if (NBITS == 11 && k == 9) return ^m_byte;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int n;
        n = mq.size();
        s = PAR;
        s[0] = m_active;
        s[1] = n == DEPTH;
        s[2] = n == 0;
        s[3] = m_ovf;
        s[7:4] = (n > 15) ? 4'd15 : 4'(n);
        return s;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd1:    return exp_status();
            2'd2:    return {16'h0, m_div};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic we,
                              input logic re, input logic [31:0] a,
                              input logic [31:0] wd);
        bit sel, pop, full, att, fend;
        if (!rst) begin
            mq.delete();
            m_active = 0;
            m_pos    = 0;
            m_d      = 1;
            m_div    = DEFD;
            m_ovf    = 0;
            return;
        end
        sel  = a[31:4] == BASE[31:4];
        fend = m_active && m_pos == flen() - 1;
        pop  = mq.size() != 0 && (!m_active || fend);
        full = mq.size() == DEPTH;
        att  = sel && we && a[3:2] == 2'd0;
        if (pop) begin
            m_byte   = mq.pop_front();
            m_d      = (m_div == 16'd0) ? 1 : int'(m_div);
            m_active = 1;
            m_pos    = 0;
        end else if (fend) begin
            m_active = 0;
        end else if (m_active) begin
            m_pos++;
        end
        if (att && (!full || pop)) mq.push_back(wd[7:0]);
        if (att && full && !pop) m_ovf = 1;
        else if (sel && re && a[3:2] == 2'd1) m_ovf = 0;
        if (sel && we && a[3:2] == 2'd2) m_div = wd[15:0];
    endtask

    task automatic step(input logic rst, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] wd);
        reset        = rst;
        write_enable = we;
        read_enable  = re;
        address      = a;
        write_data   = wd;
        data_format  = 3'($urandom);
        #1;
        if (chk_en) begin
            check("tx", 32'(tx), 32'(exp_tx()));
            check("irq", 32'(irq), 32'(mq.size() == 0 && !m_active));
            check("selected", 32'(selected), 32'(a[31:4] == BASE[31:4]));
            check("rdata", data_fetched, exp_read(a));
        end
        @(posedge clock);
        model_edge(rst, we, re, a, wd);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] wd);
        step(1, 1, 0, BASE | {28'h0, off, 2'b00}, wd);
    endtask

    task automatic peek(input string tag, input logic [1:0] off,
                        input logic [31:0] exp);
        reset        = 1;
        write_enable = 0;
        read_enable  = 1;
        address      = BASE | {28'h0, off, 2'b00};
        #1;
        check(tag, data_fetched, exp);
        step(1, 0, 1, BASE | {28'h0, off, 2'b00}, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int r;

        step(0, 0, 0, 32'h0, 32'h0);
        chk_en = 1;
        step(0, 0, 0, 32'h0, 32'h0);
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_irq", 32'(irq), 32'h1);
        peek("rst_status", 2'd1, 32'h4 | PAR);
        peek("rst_divisor", 2'd2, 32'd434);

        wr(2'd2, 32'd4);
        wr(2'd0, 32'hA5);
        idle(46);

        for (int i = 0; i < 10; i++) wr(2'd0, 32'(8'h30 + i));
        peek("ovf_status", 2'd1, 32'h8B | PAR);
        peek("ovf_cleared", 2'd1, 32'h83 | PAR);
        idle(NBITS * 4 * 9 + 10);

        wr(2'd2, 32'd0);
        wr(2'd0, 32'h01);
        idle(14);

        wr(2'd2, 32'd4);
        for (int i = 0; i < 3; i++) wr(2'd0, 32'(8'hC3 + i));
        idle(14);
        step(0, 0, 0, 32'h0, 32'h0);
        check("midrst_tx", 32'(tx), 32'h1);
        peek("midrst_status", 2'd1, 32'h4 | PAR);
        idle(50);

        wr(2'd2, 32'd2);
        wr(2'd0, 32'h07);
        idle(26);

        wr(2'd2, 32'd3);
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 99));
            a  = BASE | {28'h0, 2'($urandom), 2'($urandom)};
            wd = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                step(0, 0, 0, a, wd);
            end else if (r < 12) begin
                a[3:2] = 2'd0;
                step(1, 1, 0, a, wd);
            end else if (r < 14) begin
                a[3:2] = 2'd2;
                wd[15:0] = 16'($urandom_range(0, 5));
                step(1, 1, 0, a, wd);
            end else if (r < 30) begin
                a[3:2] = 2'd1;
                step(1, 0, 1, a, wd);
            end else if (r < 36) begin
                a[3:2] = 2'd2;
                step(1, 0, 1, a, wd);
            end else if (r < 40) begin
                a[3:2] = 2'd3;
                step(1, r[0], !r[0], a, wd);
            end else if (r < 45) begin
                a = $urandom & 32'h7FFF_FFFF;
                step(1, r[0], !r[0], a, wd);
            end else if (r < 47) begin
                if (a[3:2] == 2'd2) wd[15:0] = 16'($urandom_range(0, 5));
                step(1, 1, 1, a, wd);
            end else begin
                step(1, 0, 0, a, wd);
            end
        end
        idle(NBITS * 5 * 9 + 10);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
